// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int SEL_W_DEF    = 2;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req bit after index last.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic [SEL_W-1:0] cand_s;

  // Walk last+1 .. last+N_REQ; SEL_W-bit addition wraps because N_REQ == 2**SEL_W.
  always_comb begin
    idx    = last;
    valid  = 1'b0;
    cand_s = last;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = last + SEL_W'(i);
      idx    = (req[cand_s] && !valid) ? cand_s : idx;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter with hold limit and one-cycle turnaround for a tri-state bus.
// Optional macro BUS_ARB_LOCK_EN adds a lock input that defers the hold-limit release.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef BUS_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic             hold_expired
);

  localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_r, state_n;
  logic [SEL_W-1:0] sel_r, sel_n;
  logic [SEL_W-1:0] last_r, last_n;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_n;
  logic [N_REQ-1:0] grant_r, grant_n;
  logic             enable_r, enable_n;
  logic             hold_expired_r, hold_expired_n;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             owner_req_s;
  logic             others_s;
  logic             at_max_s;
  logic             lock_s;

`ifdef BUS_ARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_r),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign owner_req_s = req[sel_r];
  assign others_s    = |(req & ~(ONE_HOT0 << sel_r));
  assign at_max_s    = (hold_cnt_r == CNT_MAX);

  // State and registered-output flops; last starts at N_REQ-1 so req[0] wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      sel_r          <= {SEL_W{1'b0}};
      last_r         <= {SEL_W{1'b1}};
      hold_cnt_r     <= CNT_ZERO;
      grant_r        <= {N_REQ{1'b0}};
      enable_r       <= 1'b0;
      hold_expired_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      sel_r          <= sel_n;
      last_r         <= last_n;
      hold_cnt_r     <= hold_cnt_n;
      grant_r        <= grant_n;
      enable_r       <= enable_n;
      hold_expired_r <= hold_expired_n;
    end
  end

  // Next-state decision.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, TURN: begin
        state_n = pick_valid_s ? GRANT : IDLE;
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_n = TURN;
        end else if (at_max_s && others_s && !lock_s) begin
          state_n = TURN;
        end else begin
          state_n = GRANT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and hold counter.
  always_comb begin
    sel_n          = sel_r;
    last_n         = last_r;
    hold_cnt_n     = hold_cnt_r;
    grant_n        = {N_REQ{1'b0}};
    enable_n       = 1'b0;
    hold_expired_n = 1'b0;
    case (state_r)
      IDLE, TURN: begin
        if (pick_valid_s) begin
          sel_n      = pick_idx_s;
          last_n     = pick_idx_s;
          grant_n    = ONE_HOT0 << pick_idx_s;
          enable_n   = 1'b1;
          hold_cnt_n = CNT_ONE;
        end else begin
          hold_cnt_n = CNT_ZERO;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          hold_cnt_n = CNT_ZERO;
        end else if (at_max_s && lock_s) begin
          grant_n    = grant_r;
          enable_n   = 1'b1;
          hold_cnt_n = CNT_MAX;
        end else if (at_max_s && others_s) begin
          hold_expired_n = 1'b1;
          hold_cnt_n     = CNT_ZERO;
        end else if (at_max_s) begin
          // Sole requester: renew the grant in place, no turnaround.
          grant_n    = grant_r;
          enable_n   = 1'b1;
          hold_cnt_n = CNT_ONE;
        end else begin
          grant_n    = grant_r;
          enable_n   = 1'b1;
          hold_cnt_n = hold_cnt_r + CNT_ONE;
        end
      end
      default: begin
        hold_cnt_n = CNT_ZERO;
      end
    endcase
  end

  assign sel          = sel_r;
  assign enable       = enable_r;
  assign grant        = grant_r;
  assign hold_expired = hold_expired_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr; define BUS_ARB_LOCK_EN to also exercise the lock input.
module tb_bus_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] grant;
  logic       hold_expired;
`ifdef BUS_ARB_LOCK_EN
  logic       lock;
`endif

  bus_arbiter_rr #(.N_REQ(4), .SEL_W(2), .MAX_HOLD(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
`ifdef BUS_ARB_LOCK_EN
    .lock         (lock),
`endif
    .sel          (sel),
    .enable       (enable),
    .grant        (grant),
    .hold_expired (hold_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       hx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errs   = 0;

  // Reference model state (0=idle, 1=grant, 2=turn)
  int         m_state;
  logic [1:0] m_sel;
  int         m_last;
  int         m_cnt;
  logic       m_en;
  logic [3:0] m_gnt;
  logic       m_hx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sel = 2'd0; m_last = 3; m_cnt = 0;
    m_en = 1'b0; m_gnt = 4'd0; m_hx = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic lk);
    int   pick;
    logic [3:0] others;
    m_hx = 1'b0;
    if (m_state == 1) begin
      others = r & ~(4'd1 << m_sel);
      if (!r[m_sel]) begin
        m_state = 2; m_en = 1'b0; m_gnt = 4'd0;
      end else if (m_cnt == 8 && lk) begin
        m_cnt = 8;
      end else if (m_cnt == 8 && others != 4'd0) begin
        m_state = 2; m_en = 1'b0; m_gnt = 4'd0; m_hx = 1'b1;
      end else if (m_cnt == 8) begin
        m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
      end
      if (pick >= 0) begin
        m_state = 1; m_sel = pick[1:0]; m_last = pick; m_cnt = 1;
        m_en = 1'b1; m_gnt = 4'd1 << pick;
      end else begin
        m_state = 0; m_en = 1'b0; m_gnt = 4'd0;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge.
  task automatic cyc(input logic [3:0] r, input logic lk);
    exp_t e;
    req = r;
`ifdef BUS_ARB_LOCK_EN
    lock = lk;
`endif
    model_step(r, lk);
    exp_q.push_back('{sel: m_sel, en: m_en, gnt: m_gnt, hx: m_hx});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sel", 32'(sel), 32'(e.sel));
    check("enable", 32'(enable), 32'(e.en));
    check("grant", 32'(grant), 32'(e.gnt));
    check("hold_expired", 32'(hold_expired), 32'(e.hx));
  endtask

  task automatic do_reset();
    req = 4'd0;
`ifdef BUS_ARB_LOCK_EN
    lock = 1'b0;
`endif
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int         run;
    logic       prev_en;
    logic [1:0] owners[$];
    int         low_cycles;

    do_reset();
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_hx", 32'(hold_expired), 32'd0);

    // 1: single request, release, turnaround, idle
    cyc(4'b0001, 1'b0);
    check("t1_enable", 32'(enable), 32'd1);
    check("t1_grant", 32'(grant), 32'h1);
    cyc(4'b0000, 1'b0);
    check("t1_turn", 32'(enable), 32'd0);
    cyc(4'b0000, 1'b0);
    check("t1_idle", 32'(enable), 32'd0);

    // 2: all requesting -> 0,1,2,3,0 with 8-cycle tenures
    do_reset();
    run = 0; prev_en = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cyc(4'b1111, 1'b0);
      if (enable && !prev_en) owners.push_back(sel);
      if (enable) run++;
      if (!enable && prev_en) begin
        check("t2_tenure", 32'(run), 32'd8);
        check("t2_hx_pulse", 32'(hold_expired), 32'd1);
        run = 0;
      end
      prev_en = enable;
    end
    check("t2_owner_count", 32'(owners.size()), 32'd5);
    for (int i = 0; i < owners.size(); i++) begin
      check("t2_owner_order", 32'(owners[i]), 32'(i % 4));
    end

    // 3: lone requester keeps the bus with no turnaround
    do_reset();
    low_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0100, 1'b0);
      if (!enable || hold_expired) low_cycles++;
    end
    check("t3_no_turn", 32'(low_cycles), 32'd0);
    check("t3_sel", 32'(sel), 32'd2);

    // 4: owner 1 hands off while 0 and 3 arrive -> 3 wins
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b0);
    check("t4_owner1", 32'(sel), 32'd1);
    cyc(4'b1001, 1'b0);
    check("t4_turn", 32'(enable), 32'd0);
    cyc(4'b1001, 1'b0);
    check("t4_sel3", 32'(sel), 32'd3);
    check("t4_grant", 32'(grant), 32'h8);

    // 5: asynchronous reset mid-grant, then restart from req[0] priority
    cyc(4'b1001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_en", 32'(enable), 32'd0);
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_sel", 32'(sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1010, 1'b0);
    check("t5_first_sel", 32'(sel), 32'd1);

`ifdef BUS_ARB_LOCK_EN
    // 6: lock extends tenure past MAX_HOLD, release as soon as lock drops
    do_reset();
    cyc(4'b0001, 1'b0);
    for (int i = 0; i < 12; i++) cyc(4'b0011, 1'b1);
    check("t6_locked_en", 32'(enable), 32'd1);
    check("t6_locked_sel", 32'(sel), 32'd0);
    cyc(4'b0011, 1'b0);
    check("t6_release_hx", 32'(hold_expired), 32'd1);
    check("t6_release_en", 32'(enable), 32'd0);
    cyc(4'b0011, 1'b0);
    check("t6_next_sel", 32'(sel), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
